// File: rtl/execute_stage_mdu_pkg.sv
// Shared types and constants for the execute stage with the RV32M multiply/divide unit.
// Holds ALU op classes, ALU controls, M-extension ops, MDU states and the MDU request payload.
package execute_stage_mdu_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned XLEN         = DATA_WIDTH;
  localparam int unsigned MUL_STEP_DEF = 4;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE, MDU_MUL, MDU_DIV, MDU_DONE
  } mdu_state_e;

  typedef struct packed {
    muldiv_op_e      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } mdu_req_t;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/execute_stage_mdu_if.sv
// EX-stage bundle: instruction/operand inputs from ID/EX and result/handshake outputs to EX/MEM.
interface execute_stage_mdu_if;
  import execute_stage_mdu_pkg::*;

  logic            EX_valid_i;
  logic            EX_flush_i;
  logic            EX_is_muldiv_i;
  logic [XLEN-1:0] EX_alu_operand1_i;
  logic [XLEN-1:0] EX_alu_operand2_i;
  logic [2:0]      EX_alu_ctrl_funct3_i;
  logic            EX_alu_ctrl_funct7_i;
  alu_op_e         EX_ALUOp_i;
  logic [XLEN-1:0] EX_alu_result_o;
  logic            EX_alu_zeroFlag_o;
  logic            EX_valid_o;
  logic            EX_stall_o;

  modport master (
    output EX_valid_i, EX_flush_i, EX_is_muldiv_i, EX_alu_operand1_i, EX_alu_operand2_i,
           EX_alu_ctrl_funct3_i, EX_alu_ctrl_funct7_i, EX_ALUOp_i,
    input  EX_alu_result_o, EX_alu_zeroFlag_o, EX_valid_o, EX_stall_o
  );

  modport slave (
    input  EX_valid_i, EX_flush_i, EX_is_muldiv_i, EX_alu_operand1_i, EX_alu_operand2_i,
           EX_alu_ctrl_funct3_i, EX_alu_ctrl_funct7_i, EX_ALUOp_i,
    output EX_alu_result_o, EX_alu_zeroFlag_o, EX_valid_o, EX_stall_o
  );

endinterface

// File: rtl/execute_stage_mdu_alu.sv
// Single-cycle ALU path: control decode from ALUOp/funct fields and the combinational ALU.
module alu_control_unit
  import execute_stage_mdu_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output alu_ctrl_e  ctrl_c
);

  always_comb begin
    ctrl_c = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD:    ctrl_c = ALU_ADD;
      ALUOP_BRANCH: ctrl_c = ALU_SUB;
      default: begin
        unique case (funct3)
          3'd0: ctrl_c = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'd1: ctrl_c = ALU_SLL;
          3'd2: ctrl_c = ALU_SLT;
          3'd3: ctrl_c = ALU_SLTU;
          3'd4: ctrl_c = ALU_XOR;
          3'd5: ctrl_c = funct7b5 ? ALU_SRA : ALU_SRL;
          3'd6: ctrl_c = ALU_OR;
          3'd7: ctrl_c = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

module alu
  import execute_stage_mdu_pkg::*;
(
  input  alu_ctrl_e       ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y_c
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    y_c = '0;
    unique case (ctrl)
      ALU_ADD:  y_c = a + b;
      ALU_SUB:  y_c = a - b;
      ALU_SLL:  y_c = a << shamt;
      ALU_SLT:  y_c = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: y_c = XLEN'(a < b);
      ALU_XOR:  y_c = a ^ b;
      ALU_SRL:  y_c = a >> shamt;
      ALU_SRA:  y_c = XLEN'($signed(a) >>> shamt);
      ALU_OR:   y_c = a | b;
      ALU_AND:  y_c = a & b;
      default:  y_c = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage_mdu_muldiv.sv
// Multi-cycle RV32M unit: radix-2^STEP shift-add multiplier, restoring divider, 0-cycle special cases.
module muldiv_unit
  import execute_stage_mdu_pkg::*;
#(
  parameter int unsigned STEP = MUL_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  mdu_req_t        req,
  output logic            busy_c,
  output logic            done_c,
  output logic [XLEN-1:0] result
);

  localparam int unsigned MUL_CYCLES = XLEN / STEP;
  localparam int unsigned MCNT_W     = $clog2(MUL_CYCLES) + 1;
  localparam int unsigned DCNT_W     = $clog2(XLEN) + 1;
  localparam int unsigned ACC_W      = 2 * XLEN;

  if (XLEN % STEP != 0) begin : g_bad_step
    $error("muldiv_unit: STEP must divide XLEN");
  end

  mdu_state_e      state_q, state_d;
  muldiv_op_e      op_q;
  logic [ACC_W-1:0] acc_q, mcand_q, acc_d, partial, prod;
  logic [XLEN-1:0] mplier_q, rem_q, quo_q, dvsr_q, rem_d, quo_d, q_fix, r_fix;
  logic [XLEN:0]   rem_shift, trial;
  logic [MCNT_W-1:0] mcnt_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic            neg_q, rneg_q, mul_last, div_last;
  logic            a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  // Operand signedness, magnitudes and 0-cycle division cases, decoded at accept
  always_comb begin
    a_sgn       = req.op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_sgn       = req.op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    a_neg       = a_sgn && req.a[XLEN-1];
    b_neg       = b_sgn && req.b[XLEN-1];
    a_mag       = a_neg ? XLEN'(-req.a) : req.a;
    b_mag       = b_neg ? XLEN'(-req.b) : req.b;
    div_zero    = (req.b == '0);
    div_ovf     = b_sgn && (req.a == {1'b1, {(XLEN-1){1'b0}}}) && (req.b == '1);
    special     = op_is_div(req.op) && (div_zero || div_ovf);
    special_res = '0;
    if (div_zero)
      special_res = (req.op inside {MD_DIV, MD_DIVU}) ? '1 : req.a;
    else if (req.op == MD_DIV)
      special_res = req.a;
  end

  // Multiplier: retire STEP multiplier bits per cycle into the 2*XLEN accumulator
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < STEP; i++)
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    acc_d    = acc_q + partial;
    prod     = neg_q ? ACC_W'(-acc_d) : acc_d;
    mul_last = (mcnt_q == MCNT_W'(MUL_CYCLES - 1));
  end

  // Divider: one restoring step per cycle
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    rem_d     = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], ~trial[XLEN]};
    q_fix     = neg_q ? XLEN'(-quo_d) : quo_d;
    r_fix     = rneg_q ? XLEN'(-rem_d) : rem_d;
    div_last  = (dcnt_q == DCNT_W'(XLEN - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MDU_IDLE: if (start) begin
        if (!op_is_div(req.op)) state_d = MDU_MUL;
        else if (special)       state_d = MDU_DONE;
        else                    state_d = MDU_DIV;
      end
      MDU_MUL:  if (flush) state_d = MDU_IDLE; else if (mul_last) state_d = MDU_DONE;
      MDU_DIV:  if (flush) state_d = MDU_IDLE; else if (div_last) state_d = MDU_DONE;
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mcnt_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      dcnt_q   <= '0;
      result   <= '0;
    end else begin
      unique case (state_q)
        MDU_IDLE: if (start) begin
          op_q     <= req.op;
          neg_q    <= a_neg ^ b_neg;
          rneg_q   <= a_neg;
          acc_q    <= '0;
          mcand_q  <= ACC_W'(a_mag);
          mplier_q <= b_mag;
          mcnt_q   <= '0;
          rem_q    <= '0;
          quo_q    <= a_mag;
          dvsr_q   <= b_mag;
          dcnt_q   <= '0;
          if (special) result <= special_res;
        end
        MDU_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << STEP;
          mplier_q <= mplier_q >> STEP;
          mcnt_q   <= mcnt_q + MCNT_W'(1);
          if (mul_last)
            result <= (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN];
        end
        MDU_DIV: begin
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          dcnt_q <= dcnt_q + DCNT_W'(1);
          if (div_last)
            result <= (op_q inside {MD_DIV, MD_DIVU}) ? q_fix : r_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy_c = (state_q == MDU_MUL) || (state_q == MDU_DIV);
  assign done_c = (state_q == MDU_DONE);

endmodule

// File: rtl/execute_stage_mdu.sv
// Execute stage: zero-latency ALU path plus multi-cycle RV32M unit with stall and valid handshake.
module execute_stage_mdu
  import execute_stage_mdu_pkg::*;
#(
  parameter int unsigned MUL_STEP = MUL_STEP_DEF
) (
  input logic               clk,
  input logic               rst_n,
  execute_stage_mdu_if.slave ex
);

  alu_ctrl_e       alu_ctrl_c;
  logic [XLEN-1:0] alu_y_c, mdu_result;
  logic            mdu_busy_c, mdu_done_c, accept_c;
  mdu_req_t        mdu_req;

  alu_control_unit u_alu_ctrl (
    .alu_op   (ex.EX_ALUOp_i),
    .funct3   (ex.EX_alu_ctrl_funct3_i),
    .funct7b5 (ex.EX_alu_ctrl_funct7_i),
    .ctrl_c   (alu_ctrl_c)
  );

  alu u_alu (
    .ctrl (alu_ctrl_c),
    .a    (ex.EX_alu_operand1_i),
    .b    (ex.EX_alu_operand2_i),
    .y_c  (alu_y_c)
  );

  assign mdu_req  = '{op: muldiv_op_e'(ex.EX_alu_ctrl_funct3_i),
                      a:  ex.EX_alu_operand1_i,
                      b:  ex.EX_alu_operand2_i};
  assign accept_c = ex.EX_valid_i && ex.EX_is_muldiv_i && !ex.EX_flush_i
                    && !mdu_busy_c && !mdu_done_c;

  muldiv_unit #(.STEP(MUL_STEP)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept_c),
    .flush  (ex.EX_flush_i),
    .req    (mdu_req),
    .busy_c (mdu_busy_c),
    .done_c (mdu_done_c),
    .result (mdu_result)
  );

  // Output mux and stall; the DONE cycle never re-accepts the still-present instruction
  always_comb begin
    ex.EX_alu_result_o = alu_y_c;
    ex.EX_valid_o      = 1'b0;
    ex.EX_stall_o      = 1'b0;
    if (!rst_n) begin
      ex.EX_alu_result_o = '0;
    end else if (mdu_done_c) begin
      ex.EX_alu_result_o = mdu_result;
      ex.EX_valid_o      = !ex.EX_flush_i;
    end else if (mdu_busy_c) begin
      ex.EX_stall_o      = 1'b1;
    end else if (ex.EX_valid_i) begin
      ex.EX_valid_o      = !ex.EX_is_muldiv_i;
      ex.EX_stall_o      = accept_c;
    end
    ex.EX_alu_zeroFlag_o = rst_n && (ex.EX_alu_result_o == '0);
  end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Self-checking bench for execute_stage_mdu: directed cases plus random ALU/MDU ops vs a behavioural model.
module tb_execute_stage_mdu;
  import execute_stage_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  execute_stage_mdu_if ex();

  execute_stage_mdu #(.MUL_STEP(MUL_STEP_DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference results straight from the RV32 arithmetic definitions
  function automatic logic [31:0] model_alu(input alu_op_e op, input logic [2:0] f3, input logic f7,
                                            input logic [31:0] a, input logic [31:0] b);
    if (op == ALUOP_ADD)    return a + b;
    if (op == ALUOP_BRANCH) return a - b;
    case (f3)
      3'd0: return (op == ALUOP_RTYPE && f7) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3 >= 3'd4) && ((b == 32'd0) ||
           ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint    sa, sb, ua, ub;
    logic [63:0] p;
    int        ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    ia = $signed(a); ib = $signed(b);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      default: begin
        if (b == 32'd0) return (f3 == 3'd4 || f3 == 3'd5) ? 32'hFFFF_FFFF : a;
        if (is_special(f3, a, b)) return (f3 == 3'd4) ? 32'h8000_0000 : 32'd0;
        case (f3)
          3'd4: return 32'(ia / ib);
          3'd5: return a / b;
          3'd6: return 32'(ia % ib);
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 < 3'd4) return int'(XLEN / MUL_STEP_DEF) + 1;
    if (is_special(f3, a, b)) return 1;
    return int'(XLEN) + 1;
  endfunction

  task automatic drive(input logic v, input logic md, input logic fl, input alu_op_e op,
                       input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b);
    ex.EX_valid_i           = v;
    ex.EX_is_muldiv_i       = md;
    ex.EX_flush_i           = fl;
    ex.EX_ALUOp_i           = op;
    ex.EX_alu_ctrl_funct3_i = f3;
    ex.EX_alu_ctrl_funct7_i = f7;
    ex.EX_alu_operand1_i    = a;
    ex.EX_alu_operand2_i    = b;
  endtask

  // Called at posedge+1; one ALU op, checked mid-cycle, returns at the next posedge+1
  task automatic run_alu(input string tag, input alu_op_e op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(1'b1, 1'b0, 1'b0, op, f3, f7, a, b);
    @(negedge clk);
    check_eq({tag, " result"}, 64'(ex.EX_alu_result_o), 64'(exp));
    check_eq({tag, " zero"},   64'(ex.EX_alu_zeroFlag_o), 64'(exp == 32'd0));
    check_eq({tag, " valid"},  64'(ex.EX_valid_o), 64'd1);
    check_eq({tag, " stall"},  64'(ex.EX_stall_o), 64'd0);
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; holds the M op until valid, checks latency/stall/result, then idles
  task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int lat;
    bit stall_ok;
    logic [31:0] res;
    logic zf, st;
    lat = -1; stall_ok = 1'b1; res = '0; zf = 1'b0; st = 1'b0;
    drive(1'b1, 1'b1, 1'b0, ALUOP_RTYPE, f3, 1'b0, a, b);
    for (int c = 0; c <= int'(XLEN) + 8; c++) begin
      @(negedge clk);
      if (ex.EX_valid_o) begin
        lat = c; res = ex.EX_alu_result_o; zf = ex.EX_alu_zeroFlag_o; st = ex.EX_stall_o;
        break;
      end
      if (!ex.EX_stall_o) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(model_lat(f3, a, b)));
    check_eq({tag, " stall"},   64'(stall_ok), 64'd1);
    check_eq({tag, " result"},  64'(res), 64'(exp));
    check_eq({tag, " zero"},    64'(zf), 64'(exp == 32'd0));
    check_eq({tag, " done_stall"}, 64'(st), 64'd0);
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, ALUOP_ADD, 3'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, r;
    logic [2:0]  f3;
    logic        f7;
    alu_op_e     op;
    bit          seen_valid;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, ALUOP_ADD, 3'd0, 1'b0, 32'd0, 32'd0);
    #3;
    check_eq("rst valid",  64'(ex.EX_valid_o), 64'd0);
    check_eq("rst stall",  64'(ex.EX_stall_o), 64'd0);
    check_eq("rst result", 64'(ex.EX_alu_result_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_alu("add 5+7", ALUOP_RTYPE, 3'd0, 1'b0, 32'd5, 32'd7, 32'd12);
    run_alu("sub 3-3", ALUOP_RTYPE, 3'd0, 1'b1, 32'd3, 32'd3, 32'd0);

    run_mdu("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_mdu("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_mdu("divu",   3'd5, 32'd100, 32'd7, 32'd14);
    run_mdu("remu",   3'd7, 32'd100, 32'd7, 32'd2);
    run_mdu("div neg", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    run_mdu("rem neg", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    run_mdu("div by0",  3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_mdu("remu by0", 3'd7, 32'd5, 32'd0, 32'd5);
    run_mdu("div ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mdu("rem ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush during DIVU compute: no valid pulse, next ADD completes immediately
    seen_valid = 1'b0;
    drive(1'b1, 1'b1, 1'b0, ALUOP_RTYPE, 3'd5, 1'b0, 32'd1000, 32'd3);
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) ex.EX_flush_i = 1'b1;
      @(negedge clk);
      if (ex.EX_valid_o) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("flush no valid", 64'(seen_valid), 64'd0);
    run_alu("add after flush", ALUOP_RTYPE, 3'd0, 1'b0, 32'd20, 32'd22, 32'd42);
    drive(1'b0, 1'b0, 1'b0, ALUOP_ADD, 3'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_eq("idle valid", 64'(ex.EX_valid_o), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a MUL
    drive(1'b1, 1'b1, 1'b0, ALUOP_RTYPE, 3'd0, 1'b0, 32'd5, 32'd6);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst valid",  64'(ex.EX_valid_o), 64'd0);
    check_eq("midrst stall",  64'(ex.EX_stall_o), 64'd0);
    check_eq("midrst result", 64'(ex.EX_alu_result_o), 64'd0);
    check_eq("midrst zero",   64'(ex.EX_alu_zeroFlag_o), 64'd0);
    ex.EX_valid_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_mdu("mul after rst", 3'd0, 32'd3, 32'd4, 32'd12);

    // Random ALU ops across all op classes
    for (int i = 0; i < 24; i++) begin
      op = alu_op_e'(2'($urandom_range(0, 3)));
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_alu("rnd alu", op, f3, f7, a, b, model_alu(op, f3, f7, a, b));
    end

    // Random M ops with biased operands to hit special cases and sign combinations
    for (int i = 0; i < 32; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'(-int'($urandom_range(1, 50)));
        default: ;
      endcase
      r = model_mdu(f3, a, b);
      run_mdu("rnd mdu", f3, a, b, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage_mdu.md
Name: execute_stage_mdu

Overview:
- Next-generation execute stage: existing single-cycle ALU path plus a multi-cycle RV32M multiply/divide unit (MDU).
- Sits between ID/EX and EX/MEM pipeline registers.
- Raises a stall while an M-extension op is in flight and delivers a registered result with a one-cycle valid pulse.
- ALU ops pass through with zero added latency.

Parameters:
- XLEN, DATA_WIDTH (32): operand and result width.
- MUL_STEP, 4: multiplier bits retired per cycle. Must divide XLEN; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- EX_valid_i  in  1  instruction present in EX this cycle
- EX_flush_i  in  1  kill current instruction (branch/trap)
- EX_is_muldiv_i  in  1  OP with funct7=0000001
- EX_alu_operand1_i  in  XLEN  rs1 / operand A
- EX_alu_operand2_i  in  XLEN  rs2 / operand B
- EX_alu_ctrl_funct3_i  in  3  funct3 (selects MUL..REMU when is_muldiv)
- EX_alu_ctrl_funct7_i  in  1  funct7[5] for ALU control
- EX_ALUOp_i  in  alu_op_e  ALU op class
- EX_alu_result_o  out  XLEN  result
- EX_alu_zeroFlag_o  out  1  result == 0
- EX_valid_o  out  1  result valid this cycle
- EX_stall_o  out  1  hold IF/ID/EX registers

Behaviour:
- Reset (async, rst_n=0): state IDLE; MDU result reg 0; EX_valid_o=0; EX_stall_o=0.
- States: IDLE, MUL, DIV, DONE.
- ALU path: in IDLE with EX_valid_i=1 and EX_is_muldiv_i=0:
  - result = combinational ALU result; EX_valid_o=1; no stall.
- Accept: IDLE, EX_valid_i=1, EX_is_muldiv_i=1, EX_flush_i=0. Same cycle (cycle 0):
  - operands and funct3 latched;
  - EX_stall_o=1 combinationally;
  - EX_valid_o=0.
- Next state after accept:
  - funct3 0-3 (MUL, MULH, MULHSU, MULHU): MUL.
  - funct3 4-7: DIV, unless a special case applies, then DONE directly.
- MUL:
  - Operands converted to magnitudes per signedness: MUL and MULH both signed; MULHSU rs1 signed; MULHU unsigned.
  - 2*XLEN shift-add accumulator, MUL_STEP multiplier bits per cycle.
  - N = XLEN/MUL_STEP cycles; product negated if signs differ.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- DIV:
  - Restoring radix-2 on magnitudes, XLEN cycles.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a), signed ops only.
- Special cases (0 compute cycles):
  - Divisor 0: DIV/DIVU result all-ones; REM/REMU result = dividend.
  - Signed overflow (a = 0x8000_0000, b = -1): DIV result 0x8000_0000; REM result 0.
- Stall and completion:
  - EX_stall_o=1 from the accept cycle through the last compute cycle.
  - DONE: EX_stall_o=0, EX_valid_o=1, result = MDU result reg. Always returns to IDLE.
  - DONE never re-accepts: the same instruction is still present that cycle.
- Latency from accept cycle 0: MUL-class valid at cycle N+1 (9 for defaults); DIV at cycle XLEN+1 (33); special case at cycle 1.
- EX_alu_zeroFlag_o is computed on the muxed EX_alu_result_o in every state.
- Flush:
  - Flush in MUL/DIV/DONE forces IDLE next edge with no EX_valid_o pulse.
  - Flush in the accept cycle blocks the accept.
- Mid-operation reset: immediate return to IDLE with all outputs 0.
- EX_valid_i=0 in IDLE: EX_valid_o=0; result is don't-care but deterministic (ALU output).
- Width rules: accumulator 2*XLEN; divider remainder XLEN+1 bits; MUL cycle counter $clog2(XLEN/MUL_STEP)+1 bits; DIV counter $clog2(XLEN)+1 bits.

Decomposition:
- defines package additions:
  - muldiv_op_e (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU mapped to funct3);
  - mdu_state_e;
  - MUL_STEP default constant.
- Sub-module muldiv_unit holds the FSM, datapath and special cases, with a start/done/busy interface.
- Top level instantiates alu_control_unit, alu and muldiv_unit, plus the output mux and stall logic.

Test Plan:
- ADD 5+7 then SUB 3-3 back-to-back -> results 12 then 0 with zeroFlag=1; EX_valid_o high both cycles; EX_stall_o never high.
- MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB, valid at cycle 9; stall high cycles 0-8. MULH 0x80000000 × 0x80000000 -> 0x40000000.
- DIVU 100/7 -> 14 and REMU -> 2, valid at cycle 33. DIV -100/7 -> 0xFFFFFFF2 (-14), REM -> 0xFFFFFFFE (-2).
- DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0; each valid at cycle 1.
- DIVU started, EX_flush_i at cycle 10 -> state IDLE at cycle 11; no EX_valid_o; next ADD completes in the same cycle.
- MUL started, rst_n low at cycle 4 -> outputs 0 immediately; after release a new MUL 3×4 -> 12 at cycle 9.
